// File: rtl/calc_seq_pkg.sv
// Shared types and defaults for the calc neuron drive sequencer.
package calc_seq_pkg;

  localparam int unsigned default_vec_len     = 16;
  localparam int unsigned default_num_neurons = 4;
  localparam int unsigned default_acc_width   = 12;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    STREAM,
    SAMPLE,
    DONE
  } state_t;

  // Index width that never collapses to zero for a single-entry store.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/calc_seq_if.sv
// Input-vector and result handshakes of calc_seq.
interface calc_seq_if #(
  parameter int vec_len     = 16,
  parameter int num_neurons = 4,
  parameter int acc_width   = 12
);

  logic                             in_valid;
  logic                             in_ready;
  logic [vec_len-1:0]               in_vec;
  logic                             out_valid;
  logic                             out_ready;
  logic [num_neurons-1:0]           out_vec;
  logic [num_neurons*acc_width-1:0] out_acc;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_vec, out_acc
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_vec, out_acc
  );

endinterface

// File: rtl/calc_seq_wmem.sv
// Weight register file: one vec_len-bit row per neuron, single-bit combinational read.
module calc_seq_wmem #(
  parameter int vec_len     = 16,
  parameter int num_neurons = 4,
  parameter int idx_width   = 2,
  parameter int cnt_width   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [idx_width-1:0] wr_addr,
  input  logic [vec_len-1:0]   wr_data,
  input  logic [idx_width-1:0] rd_row,
  input  logic [cnt_width-1:0] rd_bit,
  output logic                 rd_data
);

  logic [vec_len-1:0] rows [num_neurons];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < num_neurons; r++) rows[r] <= '0;
    end else if (wr_en && (int'(wr_addr) < num_neurons)) begin
      rows[wr_addr] <= wr_data;
    end
  end

  assign rd_data = rows[rd_row][rd_bit];

endmodule

// File: rtl/calc_seq.sv
// Sequences bit-serial input/weight pairs into a calc neuron, one weight row
// at a time, and returns the packed activations over a valid/ready handshake.
module calc_seq
  import calc_seq_pkg::*;
#(
  parameter int vec_len     = default_vec_len,
  parameter int num_neurons = default_num_neurons,
  parameter int acc_width   = default_acc_width,
  parameter int cnt_width   = $clog2(vec_len),
  parameter int idx_width   = clog2_min1(num_neurons)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_wr_en,
  input  logic [idx_width-1:0] w_wr_addr,
  input  logic [vec_len-1:0]   w_wr_data,
  calc_seq_if.slave            bus,
  output logic                 calc_rst,
  output logic                 calc_1,
  output logic                 calc_in,
  input  logic                 calc_acted,
  input  logic [acc_width-1:0] calc_acc,
  output logic                 busy
);

  localparam logic [cnt_width-1:0] k_last = cnt_width'(vec_len - 1);
  localparam logic [idx_width-1:0] j_last = idx_width'(num_neurons - 1);

  state_t                           state, state_nxt;
  logic [vec_len-1:0]               shadow;
  logic [cnt_width-1:0]             k;
  logic [idx_width-1:0]             j;
  logic                             res_valid;
  logic [num_neurons-1:0]           res_vec;
  logic [num_neurons*acc_width-1:0] res_acc;
  logic                             w_bit;
  logic                             rdy;

  calc_seq_wmem #(
    .vec_len    (vec_len),
    .num_neurons(num_neurons),
    .idx_width  (idx_width),
    .cnt_width  (cnt_width)
  ) u_wmem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (w_wr_en && (state == IDLE)),
    .wr_addr(w_wr_addr),
    .wr_data(w_wr_data),
    .rd_row (j),
    .rd_bit (k),
    .rd_data(w_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = CLR;
      CLR:     state_nxt = STREAM;
      STREAM:  if (k == k_last) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (j == j_last) ? DONE : CLR;
      DONE:    if (res_valid && bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdy      = 1'b0;
    busy     = 1'b1;
    calc_rst = rst;
    calc_1   = 1'b0;
    calc_in  = 1'b0;
    case (state)
      IDLE: begin
        rdy  = 1'b1;
        busy = 1'b0;
      end
      CLR:    calc_rst = 1'b1;
      STREAM: begin
        calc_1  = shadow[k];
        calc_in = w_bit;
      end
      default: ;
    endcase
  end

  // out_valid is registered from DONE, so it trails DONE entry by one cycle
  // and the handshake can only complete once the consumer has seen it.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow    <= '0;
      k         <= '0;
      j         <= '0;
      res_valid <= 1'b0;
      res_vec   <= '0;
      res_acc   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          shadow <= bus.in_vec;
          j      <= '0;
        end
        CLR:    k <= '0;
        STREAM: if (k != k_last) k <= k + 1'b1;
        SAMPLE: begin
          res_vec[j]                            <= calc_acted;
          res_acc[int'(j)*acc_width +: acc_width] <= calc_acc;
          if (j != j_last) j <= j + 1'b1;
        end
        DONE:    res_valid <= !(res_valid && bus.out_ready);
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = res_valid;
  assign bus.out_vec   = res_vec;
  assign bus.out_acc   = res_acc;

endmodule

// File: tb/tb_calc_seq.sv
// Directed bench for calc_seq with a stub neuron that reports its row index.
module tb_calc_seq;

  localparam int VL = 16;
  localparam int NN = 4;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          w_wr_en;
  logic [1:0]    w_wr_addr;
  logic [VL-1:0] w_wr_data;
  logic          calc_rst, calc_1, calc_in, calc_acted, busy;
  logic [AW-1:0] calc_acc;

  int n_checks = 0;
  int n_fail   = 0;
  int rst_pulses = 0;
  int pulse_base = 0;
  int stub_j;
  int ones_cnt [NN];
  int npulse;

  calc_seq_if #(.vec_len(VL), .num_neurons(NN), .acc_width(AW)) bus ();

  calc_seq #(.vec_len(VL), .num_neurons(NN), .acc_width(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .w_wr_en   (w_wr_en),
    .w_wr_addr (w_wr_addr),
    .w_wr_data (w_wr_data),
    .bus       (bus.slave),
    .calc_rst  (calc_rst),
    .calc_1    (calc_1),
    .calc_in   (calc_in),
    .calc_acted(calc_acted),
    .calc_acc  (calc_acc),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Stub neuron: row index = number of clears seen since the run began, minus one.
  always @(posedge clk) if (calc_rst && !rst) rst_pulses <= rst_pulses + 1;
  assign stub_j     = rst_pulses - pulse_base - 1;
  assign calc_acted = stub_j[0];
  assign calc_acc   = 12'h100 + stub_j[11:0];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake_done();
    bus.out_ready = 1'b1;
    tick();
    check_eq("post_done_valid", bus.out_valid, 0);
    check_eq("post_done_ready", bus.in_ready, 1);
    bus.out_ready = 1'b0;
  endtask

  // Accepts v, runs to out_valid; optionally checks serial bits against v and w0.
  task automatic run_vec(input logic [VL-1:0] v, input bit chk_w0, input logic [VL-1:0] w0,
                         input bit wr_busy);
    int c, last_p, ph;
    pulse_base    = rst_pulses;
    bus.in_vec    = v;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    for (int n = 0; n < NN; n++) ones_cnt[n] = 0;
    c = 0; npulse = 0; last_p = 0;
    while (!bus.out_valid && c < 200) begin
      ph = c % 18;
      if (calc_rst) begin
        if (npulse > 0) check_eq("rst_gap", 64'(c - last_p), 18);
        last_p = c;
        npulse++;
      end
      if (ph >= 1 && ph <= 16 && c < 72) begin
        check_eq("stream_x", calc_1, v[ph-1]);
        if (chk_w0 && c < 18) check_eq("stream_w", calc_in, w0[ph-1]);
        if (calc_in) ones_cnt[c/18]++;
      end else if (c < 72) begin
        check_eq("idle_bits", {calc_1, calc_in}, 0);
      end
      if (wr_busy && c < 4) begin
        w_wr_en = 1'b1; w_wr_addr = 2'd2; w_wr_data = 16'hFFFF;
      end else begin
        w_wr_en = 1'b0;
      end
      tick();
      c++;
    end
    w_wr_en = 1'b0;
    check_eq("latency", 64'(c), 73);
    check_eq("rst_pulses", 64'(npulse), 4);
    check_eq("out_vec", bus.out_vec, 4'b1010);
    check_eq("out_acc", bus.out_acc, 48'h103_102_101_100);
  endtask

  initial begin
    logic [VL-1:0] w0, vmid;
    w0 = 16'hA5C3;
    rst = 1'b1; w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
    bus.in_valid = 1'b0; bus.in_vec = '0; bus.out_ready = 1'b0;

    // Reset
    tick();
    check_eq("rst_calc_rst", calc_rst, 1);
    tick();
    check_eq("rst_calc_rst2", calc_rst, 1);
    rst = 1'b0;
    tick();
    check_eq("rst_in_ready", bus.in_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_vec", bus.out_vec, 0);
    check_eq("rst_out_acc", bus.out_acc, 0);
    check_eq("rst_calc_bits", {calc_rst, calc_1, calc_in}, 0);

    // Weight rows written in IDLE
    w_wr_en = 1'b1;
    w_wr_addr = 2'd0; w_wr_data = w0;      tick();
    w_wr_addr = 2'd1; w_wr_data = 16'h1234; tick();
    w_wr_addr = 2'd2; w_wr_data = 16'h0000; tick();
    w_wr_addr = 2'd3; w_wr_data = 16'h8001; tick();
    w_wr_en = 1'b0;

    // Stream order, capture, latency
    run_vec(16'h0F0F, 1'b1, w0, 1'b0);
    check_eq("ones_row1", 64'(ones_cnt[1]), 5);
    check_eq("ones_row3", 64'(ones_cnt[3]), 2);

    // Backpressure with stray in_valid
    bus.in_valid = 1'b1; bus.in_vec = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_valid", bus.out_valid, 1);
      check_eq("bp_vec", bus.out_vec, 4'b1010);
      check_eq("bp_ready", bus.in_ready, 0);
      tick();
    end
    bus.in_valid = 1'b0;
    handshake_done();
    check_eq("idle_busy", busy, 0);

    // Writes while busy are dropped
    run_vec(16'h3C3C, 1'b0, w0, 1'b1);
    check_eq("busy_write_dropped", 64'(ones_cnt[2]), 0);
    handshake_done();

    // Same write in IDLE takes effect; out_ready held high into DONE
    w_wr_en = 1'b1; w_wr_addr = 2'd2; w_wr_data = 16'hFFFF;
    tick();
    w_wr_en = 1'b0;
    bus.out_ready = 1'b1;
    run_vec(16'h5555, 1'b0, w0, 1'b0);
    check_eq("idle_write_row2", 64'(ones_cnt[2]), 16);
    tick();
    check_eq("held_ready_valid", bus.out_valid, 0);
    check_eq("held_ready_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b0;

    // Reset mid-STREAM at neuron 1, bit 7
    vmid = 16'h00FF;
    bus.in_vec = vmid; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (26) tick();
    check_eq("mid_busy", busy, 1);
    check_eq("mid_x", calc_1, vmid[7]);
    rst = 1'b1;
    tick();
    check_eq("mid_rst_calc_rst", calc_rst, 1);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_ready", bus.in_ready, 1);
    check_eq("mid_rst_valid", bus.out_valid, 0);
    check_eq("mid_rst_vec", bus.out_vec, 0);
    check_eq("mid_rst_acc", bus.out_acc, 0);
    rst = 1'b0;
    tick();
    run_vec(16'hFFFF, 1'b0, w0, 1'b0);
    for (int n = 0; n < NN; n++) check_eq("weights_cleared", 64'(ones_cnt[n]), 0);
    handshake_done();

    // Write in the accepting cycle is used by that run
    w_wr_en = 1'b1; w_wr_addr = 2'd1; w_wr_data = 16'hFFFF;
    run_vec(16'hAAAA, 1'b0, w0, 1'b0);
    check_eq("same_cycle_row1", 64'(ones_cnt[1]), 16);
    check_eq("same_cycle_row0", 64'(ones_cnt[0]), 0);
    handshake_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
